i2s_tx: RTL and testbench

- Serializes the mixed 12-bit stereo audio bus (laudio/raudio) onto a standard I2S link for an external 16-bit audio DAC.
- Sits at the output end of the audio path, between the mixer and the board DAC pins.
- Generates BCK and LRCK itself as master from the system clock.
- Converts unsigned 12-bit mixer samples to 16-bit two's complement and captures both channels once per frame.

---
 rtl/i2s_tx.sv | 162 ++++++++++++++++
 tb/tb_i2s_tx.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx.sv
// ---------------------------------------------------------------------------
// i2s_tx -- I2S master transmitter for a 16-bit stereo DAC.
//
// Takes the unsigned 12-bit left/right mixer samples, converts them to
// 16-bit two's complement and shifts them out on a standard I2S link.
// The block is the link master, so it derives BCK and LRCK from the system
// clock itself.
//
// One frame is 32 BCK periods (16 per channel) and lasts 64*DIV clocks.
// Both channels are captured together once per frame, on the BCK falling
// edge that starts slot 0. Every output is driven straight from a register.
//
// Parameters
//   DIV       system clock cycles per BCK half-period (>= 1)
//
// Ports
//   clock     system clock, all logic on the rising edge
//   reset     synchronous, active-low reset
//   laudio    left sample, unsigned 12-bit, midscale 12'h800
//   raudio    right sample, unsigned 12-bit, midscale 12'h800
//   mute      when high at capture the frame carries zero on both channels
//   i2s_bck   bit clock
//   i2s_lrck  word select (0 = left, 1 = right)
//   i2s_data  serial data, MSB first, one BCK after the LRCK edge
//   sample    one-clock pulse on the cycle the inputs are captured
// ---------------------------------------------------------------------------
module i2s_tx #(
    parameter int DIV = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] laudio,
    input  logic [11:0] raudio,
    input  logic        mute,
    output logic        i2s_bck,
    output logic        i2s_lrck,
    output logic        i2s_data,
    output logic        sample
);

    // The divider needs at least one bit even when DIV == 1.
    localparam int              CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   DIV_LAST = CW'(DIV - 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [CW-1:0] div_cnt_reg,  div_cnt_next;
    logic          bck_reg,      bck_next;
    logic [4:0]    slot_reg,     slot_next;
    logic          lrck_reg,     lrck_next;
    logic          data_reg,     data_next;
    logic          sample_reg,   sample_next;
    logic [15:0]   left_reg,     left_next;
    logic [15:0]   right_reg,    right_next;

    // -----------------------------------------------------------------------
    // Helper terms
    // -----------------------------------------------------------------------
    logic        tick;
    logic        fall_tick;
    logic        capture;
    logic [4:0]  slot_inc;
    logic [3:0]  left_idx;
    logic [3:0]  right_idx;
    logic        slot_bit;
    logic [15:0] left_conv;
    logic [15:0] right_conv;

    assign tick      = (div_cnt_reg == DIV_LAST);
    // A tick with bck currently high drives bck low: that is the only
    // moment slot, lrck and data are allowed to move.
    assign fall_tick = tick & bck_reg;
    assign slot_inc  = slot_reg + 5'd1;
    assign capture   = fall_tick && (slot_inc == 5'd0);

    // Unsigned -> two's complement is just an MSB inversion; the 12-bit
    // value is left-justified in the 16-bit DAC word.
    assign left_conv  = mute ? 16'h0000 : {~laudio[11], laudio[10:0], 4'b0000};
    assign right_conv = mute ? 16'h0000 : {~raudio[11], raudio[10:0], 4'b0000};

    // Bit positions for the slot being entered. The one-BCK I2S delay means
    // slot n carries L[16-n] (n = 1..16) or R[32-n] (n = 17..31); both are
    // taken modulo 32 in 5 bits and only the low four bits are needed.
    assign left_idx  = 4'(5'd16 - slot_inc);
    assign right_idx = 4'(5'd0  - slot_inc);

    // Slot 0 carries the LSB of the previous right word. The right register
    // is only overwritten at this same edge, so its current LSB is exactly
    // the delayed bit; no extra storage is needed to hold it across the
    // frame boundary.
    always_comb begin
        slot_bit = 1'b0;
        if (slot_inc == 5'd0) begin
            slot_bit = right_reg[0];
        end else if (slot_inc <= 5'd16) begin
            slot_bit = left_reg[left_idx];
        end else begin
            slot_bit = right_reg[right_idx];
        end
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            div_cnt_reg <= '0;
            bck_reg     <= 1'b0;
            slot_reg    <= 5'd31;
            lrck_reg    <= 1'b1;
            data_reg    <= 1'b0;
            sample_reg  <= 1'b0;
            left_reg    <= 16'h0000;
            right_reg   <= 16'h0000;
        end else begin
            div_cnt_reg <= div_cnt_next;
            bck_reg     <= bck_next;
            slot_reg    <= slot_next;
            lrck_reg    <= lrck_next;
            data_reg    <= data_next;
            sample_reg  <= sample_next;
            left_reg    <= left_next;
            right_reg   <= right_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        div_cnt_next = tick ? '0 : div_cnt_reg + 1'b1;
        bck_next     = tick ? ~bck_reg : bck_reg;
        slot_next    = slot_reg;
        lrck_next    = lrck_reg;
        data_next    = data_reg;
        sample_next  = 1'b0;
        left_next    = left_reg;
        right_next   = right_reg;

        if (fall_tick) begin
            slot_next = slot_inc;
            lrck_next = slot_inc[4];
            data_next = slot_bit;
        end

        if (capture) begin
            left_next   = left_conv;
            right_next  = right_conv;
            sample_next = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs (all registered)
    // -----------------------------------------------------------------------
    assign i2s_bck  = bck_reg;
    assign i2s_lrck = lrck_reg;
    assign i2s_data = data_reg;
    assign sample   = sample_reg;

endmodule

// File: tb/tb_i2s_tx.sv
// ---------------------------------------------------------------------------
// tb_i2s_tx -- self-checking bench for i2s_tx.
//
// Two instances share clock, reset and inputs: DIV=8 for the main checks and
// DIV=1 for the fast-divider timing. An I2S receiver on the DIV=8 link samples
// data on BCK rising edges and rebuilds the 16-bit words, treating the first
// bit after an LRCK change as the LSB of the word that just ended.
// ---------------------------------------------------------------------------
module tb_i2s_tx;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic [11:0] laudio = 12'h000;
    logic [11:0] raudio = 12'h000;
    logic        mute   = 1'b0;

    logic bck8, lrck8, data8, sample8;
    logic bck1, lrck1, data1, sample1;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    i2s_tx #(.DIV(8)) u_div8 (
        .clock    (clk),
        .reset    (rst_n),
        .laudio   (laudio),
        .raudio   (raudio),
        .mute     (mute),
        .i2s_bck  (bck8),
        .i2s_lrck (lrck8),
        .i2s_data (data8),
        .sample   (sample8)
    );

    i2s_tx #(.DIV(1)) u_div1 (
        .clock    (clk),
        .reset    (rst_n),
        .laudio   (laudio),
        .raudio   (raudio),
        .mute     (mute),
        .i2s_bck  (bck1),
        .i2s_lrck (lrck1),
        .i2s_data (data1),
        .sample   (sample1)
    );

    // -----------------------------------------------------------------------
    // I2S receiver for the DIV=8 link
    // -----------------------------------------------------------------------
    logic        prev_bck   = 1'b0;
    logic        last_lrck  = 1'b1;
    logic [15:0] sh         = 16'h0000;
    logic [15:0] left_word  = 16'h0000;
    logic [15:0] right_word = 16'h0000;
    int          left_cnt   = 0;
    int          right_cnt  = 0;

    always @(negedge clk) begin
        if (bck8 && !prev_bck) begin
            if (lrck8 != last_lrck) begin
                if (last_lrck == 1'b0) begin
                    left_word <= {sh[14:0], data8};
                    left_cnt  <= left_cnt + 1;
                end else begin
                    right_word <= {sh[14:0], data8};
                    right_cnt  <= right_cnt + 1;
                end
                sh <= 16'h0000;
            end else begin
                sh <= {sh[14:0], data8};
            end
            last_lrck <= lrck8;
        end
        prev_bck <= bck8;
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers (no checking inside)
    // -----------------------------------------------------------------------
    task automatic wait_sample(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (sample8) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Waits for a capture, optionally changes laudio/mute change_cyc clocks
    // later, and returns the words decoded for the frame that was captured.
    task automatic get_frame(input int change_cyc, input logic [11:0] new_l,
                             input logic new_mute, output bit ok,
                             output logic [15:0] lw, output logic [15:0] rw);
        int lc0;
        int rc0;
        bit got;
        wait_sample(got);
        lc0 = left_cnt;
        rc0 = right_cnt;
        if (change_cyc > 0) begin
            repeat (change_cyc) @(posedge clk);
            laudio = new_l;
            mute   = new_mute;
        end
        ok = 1'b0;
        for (int i = 0; i < 3000 && got; i++) begin
            @(posedge clk);
            #1;
            if (left_cnt > lc0 && right_cnt > rc0 + 1) begin
                ok = 1'b1;
                break;
            end
        end
        lw = left_word;
        rw = right_word;
        $display("[TB] frame: left %h right %h ok=%0d", lw, rw, ok);
    endtask

    // -----------------------------------------------------------------------
    // Tests
    // -----------------------------------------------------------------------
    task automatic test_reset;
        int  b8_rise = -1, b8_fall = -1, s8_a = -1, s8_b = -1;
        int  s1_a = -1, s1_b = -1;
        logic lrck_at_s8 = 1'b1;
        logic lrck_at_15 = 1'b0;
        bit  toggle_bad = 1'b0;

        rst_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        tests_run++;
        if (bck8 !== 1'b0) begin tests_failed++; $display("FAIL reset_bck: got %b want 0", bck8); end
        tests_run++;
        if (lrck8 !== 1'b1) begin tests_failed++; $display("FAIL reset_lrck: got %b want 1", lrck8); end
        tests_run++;
        if (data8 !== 1'b0) begin tests_failed++; $display("FAIL reset_data: got %b want 0", data8); end
        tests_run++;
        if (sample8 !== 1'b0) begin tests_failed++; $display("FAIL reset_sample: got %b want 0", sample8); end
        tests_run++;
        if (bck1 !== 1'b0 || lrck1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_div1: got bck=%b lrck=%b want 0/1", bck1, lrck1);
        end

        @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 1; cyc <= 600; cyc++) begin
            @(posedge clk);
            #1;
            if (b8_rise < 0 && bck8) b8_rise = cyc;
            if (b8_rise > 0 && b8_fall < 0 && !bck8) b8_fall = cyc;
            if (cyc == 15) lrck_at_15 = lrck8;
            if (sample8) begin
                if (s8_a < 0) begin s8_a = cyc; lrck_at_s8 = lrck8; end
                else if (s8_b < 0) s8_b = cyc;
            end
            if (sample1) begin
                if (s1_a < 0) s1_a = cyc;
                else if (s1_b < 0) s1_b = cyc;
            end
            if (cyc <= 16 && bck1 !== cyc[0]) toggle_bad = 1'b1;
        end
        $display("[TB] timing: bck rise %0d fall %0d sample %0d/%0d div1 sample %0d/%0d",
                 b8_rise, b8_fall, s8_a, s8_b, s1_a, s1_b);

        tests_run++;
        if (b8_rise != 8) begin tests_failed++; $display("FAIL bck_rise: got %0d want 8", b8_rise); end
        tests_run++;
        if (b8_fall != 16) begin tests_failed++; $display("FAIL bck_fall: got %0d want 16", b8_fall); end
        tests_run++;
        if (s8_a != 16) begin tests_failed++; $display("FAIL first_sample: got %0d want 16", s8_a); end
        tests_run++;
        if (lrck_at_s8 !== 1'b0) begin tests_failed++; $display("FAIL lrck_at_sample: got %b want 0", lrck_at_s8); end
        tests_run++;
        if (lrck_at_15 !== 1'b1) begin tests_failed++; $display("FAIL lrck_before_sample: got %b want 1", lrck_at_15); end
        tests_run++;
        if (s8_b != 528) begin tests_failed++; $display("FAIL second_sample: got %0d want 528", s8_b); end
        tests_run++;
        if (toggle_bad) begin tests_failed++; $display("FAIL div1_toggle: got irregular bck want toggle every clock"); end
        tests_run++;
        if (s1_a != 2) begin tests_failed++; $display("FAIL div1_first_sample: got %0d want 2", s1_a); end
        tests_run++;
        if (s1_b != 66) begin tests_failed++; $display("FAIL div1_second_sample: got %0d want 66", s1_b); end
    endtask

    task automatic test_full_scale;
        bit ok;
        logic [15:0] lw, rw;
        laudio = 12'hFFF;
        raudio = 12'h000;
        get_frame(0, 12'h000, 1'b0, ok, lw, rw);
        tests_run++;
        if (!ok || lw !== 16'h7FF0) begin tests_failed++; $display("FAIL full_scale_left: got %h want 7ff0 (ok=%0d)", lw, ok); end
        tests_run++;
        if (!ok || rw !== 16'h8000) begin tests_failed++; $display("FAIL full_scale_right: got %h want 8000 (ok=%0d)", rw, ok); end
    endtask

    task automatic test_midscale;
        bit ok;
        logic [15:0] lw, rw;
        laudio = 12'h800;
        raudio = 12'h801;
        get_frame(0, 12'h000, 1'b0, ok, lw, rw);
        tests_run++;
        if (!ok || lw !== 16'h0000) begin tests_failed++; $display("FAIL midscale_left: got %h want 0000 (ok=%0d)", lw, ok); end
        tests_run++;
        if (!ok || rw !== 16'h0010) begin tests_failed++; $display("FAIL midscale_right: got %h want 0010 (ok=%0d)", rw, ok); end
    endtask

    task automatic test_mid_frame_change;
        bit ok;
        logic [15:0] lw, rw;
        laudio = 12'h123;
        raudio = 12'h000;
        // 8 BCK periods of 16 clocks after capture puts the change in slot 8.
        get_frame(128, 12'hABC, 1'b0, ok, lw, rw);
        tests_run++;
        if (!ok || lw !== 16'h9230) begin tests_failed++; $display("FAIL mid_change_current: got %h want 9230 (ok=%0d)", lw, ok); end
        get_frame(0, 12'h000, 1'b0, ok, lw, rw);
        tests_run++;
        if (!ok || lw !== 16'h2BC0) begin tests_failed++; $display("FAIL mid_change_next: got %h want 2bc0 (ok=%0d)", lw, ok); end
    endtask

    task automatic test_mute;
        bit ok;
        logic [15:0] lw, rw;
        laudio = 12'hFFF;
        raudio = 12'hFFF;
        mute   = 1'b1;
        // Drop mute right after the muted capture.
        get_frame(1, 12'hFFF, 1'b0, ok, lw, rw);
        tests_run++;
        if (!ok || lw !== 16'h0000) begin tests_failed++; $display("FAIL mute_left: got %h want 0000 (ok=%0d)", lw, ok); end
        tests_run++;
        if (!ok || rw !== 16'h0000) begin tests_failed++; $display("FAIL mute_right: got %h want 0000 (ok=%0d)", rw, ok); end
        get_frame(0, 12'h000, 1'b0, ok, lw, rw);
        tests_run++;
        if (!ok || lw !== 16'h7FF0) begin tests_failed++; $display("FAIL unmute_left: got %h want 7ff0 (ok=%0d)", lw, ok); end
        tests_run++;
        if (!ok || rw !== 16'h7FF0) begin tests_failed++; $display("FAIL unmute_right: got %h want 7ff0 (ok=%0d)", rw, ok); end
    endtask

    task automatic test_reset_mid_frame;
        bit ok;
        bit held_bad = 1'b0;
        int s8 = -1, s1 = -1;
        logic [15:0] lw, rw;
        wait_sample(ok);
        repeat (320) @(posedge clk);   // slot 20
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (bck8 !== 1'b0 || lrck8 !== 1'b1 || data8 !== 1'b0 || sample8 !== 1'b0)
                held_bad = 1'b1;
        end
        laudio = 12'h123;
        raudio = 12'hABC;
        @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            #1;
            if (s8 < 0 && sample8) s8 = cyc;
            if (s1 < 0 && sample1) s1 = cyc;
        end
        $display("[TB] restart: sample after %0d clocks, div1 after %0d", s8, s1);
        tests_run++;
        if (held_bad || !ok) begin tests_failed++; $display("FAIL midreset_outputs: got non-reset outputs during reset want bck=0 lrck=1 data=0"); end
        tests_run++;
        if (s8 != 16) begin tests_failed++; $display("FAIL midreset_restart: got %0d want 16", s8); end
        tests_run++;
        if (s1 != 2) begin tests_failed++; $display("FAIL midreset_div1_restart: got %0d want 2", s1); end
        get_frame(0, 12'h000, 1'b0, ok, lw, rw);
        tests_run++;
        if (!ok || lw !== 16'h9230) begin tests_failed++; $display("FAIL after_reset_left: got %h want 9230 (ok=%0d)", lw, ok); end
        tests_run++;
        if (!ok || rw !== 16'h2BC0) begin tests_failed++; $display("FAIL after_reset_right: got %h want 2bc0 (ok=%0d)", rw, ok); end
    endtask

    initial begin
        test_reset();
        test_full_scale();
        test_midscale();
        test_mid_frame_change();
        test_mute();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
